imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the number of consecutive loader grants allowed while fetch waits (range 1..7).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, the word-address width of the instruction memory.
REQ-003 SHALL have ports clk in 1 (the single clock, rising edge) and rst_n in 1 (asynchronous active-low reset).
REQ-004 SHALL have ports f_req in 1, f_addr in 32 and f_gnt out 1 for fetch read requests (byte address).
REQ-005 SHALL have ports f_rvalid out 1 and f_rdata out 32 for fetch read data.
REQ-006 SHALL have ports l_req in 1, l_we in 1, l_addr in 32, l_wdata in 32 and l_gnt out 1 for loader read/write requests.
REQ-007 SHALL have ports l_rvalid out 1 and l_rdata out 32 for loader read data.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out DEPTH_LOG2, mem_wdata out 32 and mem_rdata in 32 for the single-port memory, which has 1-cycle read latency.
REQ-009 SHALL have port err out 1, a one-cycle out-of-range pulse (present only with IMEM_ARB_ERR_EN).

Function
REQ-010 SHALL grant at most one requester per cycle; the grant is combinational from the request in the same cycle; a requester holds req and its address until it sees gnt high.
REQ-011 SHALL use the arbitration policy "loader wins a tie" unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-012 SHALL update starve_cnt (3 bits) as follows: +1 on a cycle with f_req high and l_gnt high; cleared on f_gnt, or on any cycle with f_req low; never exceeds STARVE_MAX.
REQ-013 SHALL, on a grant, drive mem_en=1 and mem_addr = addr[DEPTH_LOG2+1:2] (word index; addr[1:0] ignored); mem_we = l_we only for a loader grant, otherwise 0; mem_wdata = l_wdata.
REQ-014 SHALL register an owner state machine, states IDLE / RD_F / RD_L: a fetch read grant goes to RD_F, a loader read grant goes to RD_L, and a write or no grant goes to IDLE.
REQ-015 SHALL, in RD_F, pulse f_rvalid and present f_rdata = mem_rdata; in RD_L, likewise pulse l_rvalid and present l_rdata; read latency is exactly 1 cycle after gnt.
REQ-016 SHALL hold rdata outputs between pulses, with rvalid low.
REQ-017 SHALL produce no rvalid for a write.
REQ-018 SHALL allow back-to-back grants every cycle, so a new grant can coincide with the previous read's rvalid.
REQ-019 SHALL, with no request, drive mem_en=0, mem_we=0 and state IDLE.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we and err to 0, f_rdata and l_rdata to 0, starve_cnt to 0 and state to IDLE.
REQ-021 SHALL drop a read outstanding when reset asserts; no rvalid follows reset release.
REQ-022 SHALL allow the first grant on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with macro IMEM_ARB_ERR_EN defined, treat a granted request with addr[31:DEPTH_LOG2+2] != 0 as follows: mem_en=0; the next cycle pulses err together with the requester's rvalid (reads only) and rdata=0; writes are dropped.
REQ-024 SHALL, without IMEM_ARB_ERR_EN, have no err port, truncate upper address bits and access memory normally.

Verification
REQ-025 SHALL cover: f_req with f_addr=0x8 alone, mem word 2 = 0xDEADBEEF -> f_gnt in the same cycle, mem_addr=2, f_rvalid next cycle with f_rdata=0xDEADBEEF.
REQ-026 SHALL cover: f_req and l_req held high continuously, STARVE_MAX=4 -> grant order L,L,L,L,F,L,L,L,L,F...
REQ-027 SHALL cover: loader write l_addr=0x10 with l_wdata=0x12345678, then fetch of 0x10 -> mem_we=1 at index 4 with no l_rvalid; f_rdata=0x12345678.
REQ-028 SHALL cover: rst_n pulled low in the cycle after a fetch grant -> f_rvalid stays 0 and all outputs are 0 immediately.
REQ-029 SHALL cover: with IMEM_ARB_ERR_EN, fetch of 0x00001000 -> mem_en=0; next cycle err=1, f_rvalid=1 and f_rdata=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. loader) in front of a single-port,
// 1-cycle-latency instruction memory. Define IMEM_ARB_ERR_EN to add out-of-range detection and the err port.
module imem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef IMEM_ARB_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_F = 2'd1;
  localparam logic [1:0] RD_L = 2'd2;
  localparam logic [2:0] STARVE_MAX_C = 3'(STARVE_MAX);

  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic        fetch_prio;
  logic        any_gnt;
  logic        oor;
  logic        rsp_zero;
  logic [31:0] sel_addr;
  logic        addr_unused;

  // Grants are combinational, so they are gated with rst_n to be held low during reset.
  assign fetch_prio = (starve_cnt_q == STARVE_MAX_C);
  assign f_gnt      = rst_n & f_req & (~l_req | fetch_prio);
  assign l_gnt      = rst_n & l_req & ~(f_req & fetch_prio);
  assign any_gnt    = f_gnt | l_gnt;
  assign sel_addr   = l_gnt ? l_addr : f_addr;

  // Byte-offset bits (and, without range checking, the upper bits) are intentionally ignored.
  assign addr_unused = ^sel_addr;

`ifdef IMEM_ARB_ERR_EN
  logic err_q, err_d;

  assign oor      = (sel_addr[31:DEPTH_LOG2+2] != '0);
  assign rsp_zero = err_q;
  assign err_d    = any_gnt & oor;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign oor      = 1'b0;
  assign rsp_zero = 1'b0;
`endif

  assign mem_en    = any_gnt & ~oor;
  assign mem_we    = l_gnt & l_we & ~oor;
  assign mem_addr  = sel_addr[DEPTH_LOG2+1:2];
  assign mem_wdata = l_wdata;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!f_req || f_gnt) begin
      starve_cnt_d = 3'd0;
    end else if (l_gnt && (starve_cnt_q < STARVE_MAX_C)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end

    state_d = IDLE;
    if (f_gnt)              state_d = RD_F;
    else if (l_gnt && !l_we) state_d = RD_L;

    // Read data is presented live in the response cycle and held afterwards.
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    if (state_q == RD_F) f_rdata_d = rsp_zero ? 32'd0 : mem_rdata;
    if (state_q == RD_L) l_rdata_d = rsp_zero ? 32'd0 : mem_rdata;
  end

  assign f_rvalid = (state_q == RD_F);
  assign l_rvalid = (state_q == RD_L);
  assign f_rdata  = f_rdata_d;
  assign l_rdata  = l_rdata_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 3'd0;
      state_q      <= IDLE;
      f_rdata_q    <= 32'd0;
      l_rdata_q    <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      state_q      <= state_d;
      f_rdata_q    <= f_rdata_d;
      l_rdata_q    <= l_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a behavioural 1-cycle-latency memory.
// Checks are taken 1 time unit after the falling edge, where inputs are driven.
module tb_imem_arbiter;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0]   f_addr = '0, l_addr = '0, l_wdata = '0;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [31:0]   f_rdata, l_rdata, mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [DL-1:0] mem_addr;
`ifdef IMEM_ARB_ERR_EN
  logic          err;
`endif

  logic          pre_en = 1'b0;
  logic [DL-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  logic [31:0]   mem [0:(1<<DL)-1];

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.STARVE_MAX(4), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic preload(input logic [DL-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h8; l_addr = 32'h4;
    @(negedge clk); #1;
    checks++; if (f_gnt !== 1'b0)    begin errors++; $display("FAIL rst_f_gnt got %b exp 0", f_gnt); end
    checks++; if (l_gnt !== 1'b0)    begin errors++; $display("FAIL rst_l_gnt got %b exp 0", l_gnt); end
    checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL rst_rvalid got %b/%b exp 0/0", f_rvalid, l_rvalid); end
    checks++; if (f_rdata !== 32'd0 || l_rdata !== 32'd0)
      begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", f_rdata, l_rdata); end
    f_req = 1'b0; l_req = 1'b0;
    preload(10'd2, 32'hDEADBEEF);
    preload(10'd1, 32'h1111_0001);
    preload(10'd3, 32'h3333_0003);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_read;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h8; #1;
    checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0)
      begin errors++; $display("FAIL fr_gnt got f=%b l=%b exp f=1 l=0", f_gnt, l_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd2)
      begin errors++; $display("FAIL fr_mem got en=%b we=%b addr=%0d exp 1 0 2", mem_en, mem_we, mem_addr); end
    @(negedge clk);
    f_req = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL fr_rsp got v=%b d=%h exp 1 deadbeef", f_rvalid, f_rdata); end
    checks++; if (mem_en !== 1'b0 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL fr_idle got en=%b lv=%b exp 0 0", mem_en, l_rvalid); end
    @(negedge clk); #1;
    checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL fr_hold got v=%b d=%h exp 0 deadbeef", f_rvalid, f_rdata); end
  endtask

  task automatic test_starvation;
    logic prev_f;
    logic exp_f;
    prev_f = 1'b0;
    f_addr = 32'hC; l_addr = 32'h4; l_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f_req = 1'b1; l_req = 1'b1; #1;
      exp_f = (i % 5 == 4);
      checks++; if (f_gnt !== exp_f || l_gnt !== !exp_f)
        begin errors++; $display("FAIL starve_gnt[%0d] got f=%b l=%b exp f=%b", i, f_gnt, l_gnt, exp_f); end
      checks++; if (mem_addr !== (exp_f ? 10'd3 : 10'd1))
        begin errors++; $display("FAIL starve_addr[%0d] got %0d", i, mem_addr); end
      if (i > 0) begin
        checks++;
        if (prev_f ? (f_rvalid !== 1'b1 || l_rvalid !== 1'b0 || f_rdata !== 32'h3333_0003)
                   : (l_rvalid !== 1'b1 || f_rvalid !== 1'b0 || l_rdata !== 32'h1111_0001))
          begin errors++; $display("FAIL starve_rsp[%0d] got fv=%b lv=%b fd=%h ld=%h", i, f_rvalid, l_rvalid, f_rdata, l_rdata); end
      end
      prev_f = exp_f;
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h3333_0003 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL starve_last got fv=%b fd=%h lv=%b exp 1 33330003 0", f_rvalid, f_rdata, l_rvalid); end
  endtask

  task automatic test_write_then_fetch;
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'h12345678; #1;
    checks++; if (l_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd4 || mem_wdata !== 32'h12345678)
      begin errors++; $display("FAIL wr_mem got g=%b en=%b we=%b a=%0d d=%h", l_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h13; #1;
    checks++; if (l_rvalid !== 1'b0 || f_rvalid !== 1'b0)
      begin errors++; $display("FAIL wr_no_rvalid got lv=%b fv=%b exp 0 0", l_rvalid, f_rvalid); end
    checks++; if (f_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4)
      begin errors++; $display("FAIL wr_fetch got g=%b we=%b a=%0d exp 1 0 4", f_gnt, mem_we, mem_addr); end
    @(negedge clk);
    f_req = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h12345678 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL wr_readback got v=%b d=%h lv=%b exp 1 12345678 0", f_rvalid, f_rdata, l_rvalid); end
  endtask

  task automatic test_reset_outstanding;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h8; #1;
    checks++; if (f_gnt !== 1'b1)
      begin errors++; $display("FAIL ro_gnt got %b exp 1", f_gnt); end
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b0 || f_gnt !== 1'b0 || mem_en !== 1'b0 || f_rdata !== 32'd0 || l_rdata !== 32'd0)
      begin errors++; $display("FAIL ro_async got fv=%b g=%b en=%b fd=%h ld=%h exp all 0", f_rvalid, f_gnt, mem_en, f_rdata, l_rdata); end
    @(negedge clk);
    f_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL ro_release got fv=%b lv=%b exp 0 0", f_rvalid, l_rvalid); end
    @(negedge clk); #1;
    checks++; if (f_rvalid !== 1'b0)
      begin errors++; $display("FAIL ro_dropped got fv=%b exp 0", f_rvalid); end
    f_req = 1'b1; f_addr = 32'h8; #1;
    checks++; if (f_gnt !== 1'b1)
      begin errors++; $display("FAIL ro_first_gnt got %b exp 1", f_gnt); end
    @(negedge clk);
    f_req = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL ro_first_rsp got v=%b d=%h exp 1 deadbeef", f_rvalid, f_rdata); end
  endtask

`ifdef IMEM_ARB_ERR_EN
  task automatic test_out_of_range;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h0000_1000; #1;
    checks++; if (f_gnt !== 1'b1 || mem_en !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL oor_req got g=%b en=%b err=%b exp 1 0 0", f_gnt, mem_en, err); end
    @(negedge clk);
    f_req = 1'b0; #1;
    checks++; if (err !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== 32'd0)
      begin errors++; $display("FAIL oor_rsp got err=%b v=%b d=%h exp 1 1 0", err, f_rvalid, f_rdata); end
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0000_2010; l_wdata = 32'hBAD0BAD0; #1;
    checks++; if (l_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0)
      begin errors++; $display("FAIL oor_wr got g=%b en=%b we=%b exp 1 0 0", l_gnt, mem_en, mem_we); end
    @(negedge clk);
    l_req = 1'b0; l_we = 1'b0; #1;
    checks++; if (err !== 1'b1 || l_rvalid !== 1'b0)
      begin errors++; $display("FAIL oor_wr_rsp got err=%b lv=%b exp 1 0", err, l_rvalid); end
  endtask
`else
  task automatic test_truncation;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h0000_1008; #1;
    checks++; if (f_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'd2)
      begin errors++; $display("FAIL trunc_req got g=%b en=%b a=%0d exp 1 1 2", f_gnt, mem_en, mem_addr); end
    @(negedge clk);
    f_req = 1'b0; #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL trunc_rsp got v=%b d=%h exp 1 deadbeef", f_rvalid, f_rdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_read();
    test_starvation();
    test_write_then_fetch();
    test_reset_outstanding();
`ifdef IMEM_ARB_ERR_EN
    test_out_of_range();
`else
    test_truncation();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
